reference_index_gen: RTL
========================

// Module: reference_index_gen
// PURPOSE
//  Sweeps read addresses for the reference sample buffer. On start, emits one
//  pass of buffer_length indices, from start_index upward with modulo wrap.
//  Repeats for num_passes passes, then signals done.
//  Sits directly upstream of the reference buffer (drives its index stream) inside the CAF.
// PARAMETERS
//  buffer_length  10  entries in reference buffer; indices are 0..buffer_length-1
//  buffer_bits    4   width of index; must satisfy 2**buffer_bits >= buffer_length
//  pass_bits      8   width of num_passes / pass counter
// PORTS
//  clk                  in   1            clock, all logic on rising edge
//  rst                  in   1            asynchronous, active-high reset
//  start                in   1            request a sweep; sampled only in IDLE
//  start_index          in   buffer_bits  first index of every pass; latched on accepted start
//  num_passes           in   pass_bits    passes to run; latched on accepted start
//  m_axis_tready        in   1            downstream ready for index beat
//  m_axis_index_tvalid  out  1            index beat valid
//  m_axis_index_tdata   out  buffer_bits  index beat
//  busy                 out  1            high in RUN
//  done                 out  1            one-cycle pulse at end of sweep
//  abort                in   1            only when REF_INDEX_GEN_ABORT_EN defined
// BEHAVIOUR
//  - Reset (async assert, any state): IDLE; valid=0, tdata=0, busy=0, done=0, counters=0.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: start=1 latches inputs.
//      num_passes!=0 -> RUN; num_passes==0 -> DONE with no beats.
//    RUN: valid=1. Beat accepted when valid && m_axis_tready.
//    DONE: done=1 for exactly one cycle, valid=0, then IDLE.
//  - Latency: start accepted in cycle N -> valid=1 and tdata=start_index in cycle N+1.
//  - Handshake: once asserted, valid stays high until the last beat is accepted.
//    tdata holds stable while valid && !m_axis_tready. Throughput is 1 beat/clk when ready is held high.
//  - Index update on accept: tdata==buffer_length-1 -> 0, else tdata+1.
//    Beat counter counts 0..buffer_length-1 per pass, independent of tdata.
//  - After buffer_length beats, the pass counter increments. The next pass restarts at the latched start_index.
//  - Last beat of last pass accepted in cycle M -> cycle M+1: valid=0, busy=0, state DONE, done=1.
//  - start_index >= buffer_length: treated as 0 (latched value forced to 0).
//  - start ignored while busy or in DONE.
//    start asserted in the DONE cycle is not queued.
//  - Inputs change during RUN: no effect; only the latched copies are used.
//  - Total beats per sweep = num_passes * buffer_length; the output never exceeds buffer_length-1.
// CONFIGURATION
//  REF_INDEX_GEN_ABORT_EN defined: abort port exists.
//    abort=1 in RUN -> next cycle valid=0, state DONE, done pulses. A beat accepted in the abort cycle still counts.
//    abort is ignored in IDLE and DONE.
//  Not defined: no abort port; a sweep always runs to completion or reset.
// TESTING
//  - Reset: rst=1 mid-RUN -> same cycle valid=0, busy=0; after release, IDLE with tdata=0.
//  - Basic sweep, defaults, start_index=3, num_passes=2, ready=1:
//    20 beats 3..9,0..2,3..9,0..2 on consecutive cycles; done 1 cycle after last beat.
//  - Backpressure: ready toggles 1/0 each cycle, start_index=0, num_passes=1:
//    tdata held stable while ready=0; beats are exactly 0..9, 10 accepts; done after 10th accept.
//  - Edges: num_passes=0 -> done at N+1, valid never high.
//    start_index=12 -> first beat 0.
//    start during RUN -> ignored, beat count unchanged.
//  - Abort (REF_INDEX_GEN_ABORT_EN): abort after 4th accept -> valid low next cycle, done pulses, 4 beats total.

Source files
------------

// File: rtl/reference_index_gen.sv
// Read-address sweeper for the CAF reference buffer: emits num_passes passes of
// buffer_length indices on an AXI-Stream-style beat interface. Optional abort port: REF_INDEX_GEN_ABORT_EN.
module reference_index_gen #(
  parameter int buffer_length = 10,
  parameter int buffer_bits   = 4,
  parameter int pass_bits     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [buffer_bits-1:0] start_index,
  input  logic [pass_bits-1:0]   num_passes,
  input  logic                   m_axis_tready,
`ifdef REF_INDEX_GEN_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   m_axis_index_tvalid,
  output logic [buffer_bits-1:0] m_axis_index_tdata,
  output logic                   busy,
  output logic                   done
);

  localparam logic [buffer_bits-1:0] last_index = buffer_bits'(buffer_length - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_n;
  logic [buffer_bits-1:0] index_q, index_n;
  logic [buffer_bits-1:0] beat_q, beat_n;
  logic [pass_bits-1:0]   pass_q, pass_n;
  logic [buffer_bits-1:0] start_q, start_n;
  logic [pass_bits-1:0]   passes_q, passes_n;
  logic                   accept;

  // Outputs decode straight from the state register, so an async reset drops them immediately.
  assign m_axis_index_tvalid = (state_q == RUN);
  assign busy                = (state_q == RUN);
  assign done                = (state_q == DONE);
  assign m_axis_index_tdata  = index_q;
  assign accept              = m_axis_index_tvalid && m_axis_tready;

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through this block infers a latch.
    state_n  = state_q;
    index_n  = index_q;
    beat_n   = beat_q;
    pass_n   = pass_q;
    start_n  = start_q;
    passes_n = passes_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Out-of-range start positions collapse to index 0.
          start_n  = (int'(start_index) >= buffer_length) ? '0 : start_index;
          passes_n = num_passes;
          index_n  = start_n;
          beat_n   = '0;
          pass_n   = '0;
          state_n  = (num_passes != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept) begin
          if (beat_q == last_index) begin
            beat_n  = '0;
            index_n = start_q;
            pass_n  = pass_q + 1'b1;
            if (pass_q == passes_q - 1'b1) state_n = DONE;
          end else begin
            beat_n  = beat_q + 1'b1;
            index_n = (index_q == last_index) ? '0 : index_q + 1'b1;
          end
        end
`ifdef REF_INDEX_GEN_ABORT_EN
        // A beat taken in the abort cycle has already updated the counters above.
        if (abort) state_n = DONE;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      beat_q   <= '0;
      pass_q   <= '0;
      start_q  <= '0;
      passes_q <= '0;
    end else begin
      state_q  <= state_n;
      index_q  <= index_n;
      beat_q   <= beat_n;
      pass_q   <= pass_n;
      start_q  <= start_n;
      passes_q <= passes_n;
    end
  end

endmodule
